// File: rtl/mod_divider_arbiter.sv
// Round-robin front end that shares one fixed-latency, clken-gated divider between NREQ requesters.
// A tag pipe matched to the divider latency sends each quotient/remainder back to the requester that issued it.
module mod_divider_arbiter #(
  parameter int WIDTH       = 32,
  parameter int NREQ        = 4,
  parameter int DIV_LATENCY = 12
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             clk_en,
  input  logic [NREQ-1:0]                  req_valid,
  input  logic [NREQ*WIDTH-1:0]            req_numer,
  input  logic [NREQ*WIDTH-1:0]            req_denom,
  output logic [NREQ-1:0]                  req_ready,
  output logic [WIDTH-1:0]                 div_numer,
  output logic [WIDTH-1:0]                 div_denom,
  input  logic [WIDTH-1:0]                 div_quotient,
  input  logic [WIDTH-1:0]                 div_remain,
  output logic [NREQ-1:0]                  rsp_valid,
  output logic [WIDTH-1:0]                 rsp_quotient,
  output logic [WIDTH-1:0]                 rsp_remain,
  output logic                             rsp_div0,
  output logic [$clog2(DIV_LATENCY+2)-1:0] in_flight
);

  localparam int IDW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int SW   = IDW + 1;
  localparam int CW   = $clog2(DIV_LATENCY + 2);
  // Stage 0 shadows the operand register; the remaining DIV_LATENCY stages shadow the divider.
  localparam int LAST = DIV_LATENCY;

  localparam logic [IDW-1:0] ID_ONE  = IDW'(1);
  localparam logic [IDW-1:0] ID_LAST = IDW'(NREQ - 1);
  localparam logic [CW-1:0]  CNT_ONE = CW'(1);

  logic [IDW-1:0]   ptr_r;
  logic [IDW-1:0]   grant_id_s;
  logic [IDW-1:0]   ptr_next_s;
  logic [SW-1:0]    scan_s;
  logic             found_s;
  logic [NREQ-1:0]  grant_s;
  logic             xfer_s;
  logic [WIDTH-1:0] sel_numer_s;
  logic [WIDTH-1:0] sel_denom_s;
  logic             sel_div0_s;
  logic [LAST:0]    tag_valid_r;
  logic [LAST:0]    tag_div0_r;
  logic [IDW-1:0]   tag_id_r [LAST+1];
  logic             ret_s;
  logic [NREQ-1:0]  ret_onehot_s;

  // Round-robin search from the pointer, wrapping at NREQ-1, plus operand selection.
  always_comb begin
    grant_s    = '0;
    grant_id_s = '0;
    found_s    = 1'b0;
    scan_s     = '0;
    for (int k = 0; k < NREQ; k++) begin
      scan_s = {1'b0, ptr_r} + SW'(k);
      if (scan_s >= SW'(NREQ)) begin
        scan_s = scan_s - SW'(NREQ);
      end else begin
        scan_s = scan_s;
      end
      if (!found_s && req_valid[scan_s[IDW-1:0]]) begin
        found_s    = 1'b1;
        grant_id_s = scan_s[IDW-1:0];
      end else begin
        found_s    = found_s;
      end
    end
    if (found_s && clk_en && !reset) begin
      grant_s[grant_id_s] = 1'b1;
    end else begin
      grant_s = '0;
    end
    xfer_s      = |grant_s;
    sel_numer_s = req_numer[grant_id_s*WIDTH +: WIDTH];
    sel_denom_s = req_denom[grant_id_s*WIDTH +: WIDTH];
    sel_div0_s  = (sel_denom_s == {WIDTH{1'b0}});
    if (grant_id_s == ID_LAST) begin
      ptr_next_s = {IDW{1'b0}};
    end else begin
      ptr_next_s = grant_id_s + ID_ONE;
    end
    ret_s        = tag_valid_r[LAST];
    ret_onehot_s = '0;
    ret_onehot_s[tag_id_r[LAST]] = 1'b1;
  end

  assign req_ready = grant_s;

  // Operand register, round-robin pointer and tag pipe; everything freezes while clk_en is low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_r       <= '0;
      div_numer   <= '0;
      div_denom   <= '0;
      tag_valid_r <= '0;
      tag_div0_r  <= '0;
      for (int k = 0; k <= LAST; k++) begin
        tag_id_r[k] <= '0;
      end
    end else if (clk_en) begin
      if (xfer_s) begin
        div_numer <= sel_numer_s;
        div_denom <= sel_denom_s;
        ptr_r     <= ptr_next_s;
      end
      tag_valid_r <= {tag_valid_r[LAST-1:0], xfer_s};
      tag_div0_r  <= {tag_div0_r[LAST-1:0], sel_div0_s};
      tag_id_r[0] <= grant_id_s;
      for (int k = 1; k <= LAST; k++) begin
        tag_id_r[k] <= tag_id_r[k-1];
      end
    end
  end

  // Return path capture and outstanding-operation counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rsp_valid    <= '0;
      rsp_quotient <= '0;
      rsp_remain   <= '0;
      rsp_div0     <= 1'b0;
      in_flight    <= '0;
    end else if (clk_en) begin
      if (ret_s) begin
        rsp_valid    <= ret_onehot_s;
        rsp_quotient <= div_quotient;
        rsp_remain   <= div_remain;
        rsp_div0     <= tag_div0_r[LAST];
      end else begin
        rsp_valid    <= '0;
        rsp_div0     <= 1'b0;
      end
      case ({xfer_s, ret_s})
        2'b10:   in_flight <= in_flight + CNT_ONE;
        2'b01:   in_flight <= in_flight - CNT_ONE;
        default: in_flight <= in_flight;
      endcase
    end
  end

endmodule
